// File: rtl/riscv_fetch_stage.sv
// rtl/riscv_fetch_stage.sv - instruction fetch stage: PC, in-order imem requests, instruction buffer to decode
module riscv_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcsel_in,
  input  logic [31:0] alu_target_in,
  input  logic        stall_in,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [31:0]   inst_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   tag_mem  [FIFO_DEPTH];
  logic          req_fire, rsp_any, rsp_take, pop;
  logic [CW:0]   credit_used;
  logic          unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^alu_target_in[1:0];

  // Credit covers both in-flight requests and buffered entries, so the buffer can never overflow.
  assign credit_used    = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = reset && !pcsel_in && (credit_used < DEPTH_W) && (drop_q == '0);
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_any        = imem_rsp_valid && (out_q != '0);
  assign rsp_take       = rsp_any && (drop_q == '0) && !pcsel_in;

  assign inst_valid_out = (cnt_q != '0);
  assign pop            = inst_valid_out && !stall_in;
  assign inst_out       = inst_valid_out ? inst_mem[rd_q] : NOP_INST;
  assign pc_out         = inst_valid_out ? pc_mem[rd_q] : pc_q;
  assign pc4_out        = pc_out + 32'd4;

  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q + CW'(req_fire) - CW'(rsp_any);
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    if (pcsel_in) begin
      // Every request still in flight will come back stale; count them out.
      pc_d     = {alu_target_in[31:2], 2'b00};
      drop_d   = out_q - CW'(rsp_any);
      cnt_d    = '0;
      wr_d     = '0;
      rd_d     = '0;
      tag_wr_d = '0;
      tag_rd_d = '0;
    end else begin
      if (req_fire) begin
        pc_d     = pc_q + 32'd4;
        tag_wr_d = tag_wr_q + AW'(1);
      end
      if ((drop_q != '0) && rsp_any) drop_d = drop_q - CW'(1);
      if (rsp_take) begin
        wr_d     = wr_q + AW'(1);
        tag_rd_d = tag_rd_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(rsp_take) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_q] <= pc_q;
    if (rsp_take) begin
      inst_mem[wr_q] <= imem_rsp_data;
      pc_mem[wr_q]   <= tag_mem[tag_rd_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) assert (!(rsp_take && !pop && (cnt_q == CW'(FIFO_DEPTH))));
  end
endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb/tb_riscv_fetch_stage.sv - directed vectors, corner sequences and random run against a queue model
module tb_riscv_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          D        = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, reset, pcsel_in, stall_in, imem_req_valid, imem_req_ready, imem_rsp_valid, inst_valid_out;
  logic [31:0] alu_target_in, imem_addr, imem_rsp_data, inst_out, pc_out, pc4_out;
  int n_tests = 0;
  int n_fail  = 0;

  riscv_fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(D), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .pcsel_in(pcsel_in), .alu_target_in(alu_target_in), .stall_in(stall_in),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .inst_valid_out(inst_valid_out),
    .inst_out(inst_out), .pc_out(pc_out), .pc4_out(pc4_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic pcsel; logic [31:0] tgt; logic stall; logic ready; logic rsp_v; logic [31:0] rsp_d;
    logic e_req; logic [31:0] e_addr; logic e_iv; logic [31:0] e_inst; logic [31:0] e_pc;
  } vec_t;

  ent_t        q_buf[$];
  logic [31:0] q_tags[$];
  mreq_t       mq[$];
  int          m_out, m_drop, cyc, lat_min, lat_max;
  logic [31:0] m_pc;
  logic        m_req_c, cur_pcsel, cur_stall, cur_ready, cur_rsp;
  logic [31:0] cur_tgt, cur_rdata;
  vec_t        vt[16];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0F13;
  endfunction

  function automatic vec_t mk(input logic pcsel, input logic [31:0] tgt, input logic stall, input logic rsp_v,
                              input logic [31:0] rsp_d, input logic e_req, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_pc);
    vec_t v;
    v.pcsel = pcsel; v.tgt = tgt; v.stall = stall; v.ready = 1'b1; v.rsp_v = rsp_v; v.rsp_d = rsp_d;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
    v.e_inst = e_iv ? dat(e_pc) : NOP;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected DUT event", nm);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_req"}, 32'(imem_req_valid), 0);
    chk({nm, "_iv"}, 32'(inst_valid_out), 0);
    chk({nm, "_inst"}, inst_out, NOP);
    chk({nm, "_pc"}, pc_out, RESET_PC);
    chk({nm, "_pc4"}, pc4_out, RESET_PC + 32'd4);
  endtask

  task automatic model_reset();
    q_buf.delete(); q_tags.delete(); mq.delete();
    m_out = 0; m_drop = 0; m_pc = RESET_PC;
  endtask

  task automatic drive(input logic pcsel, input logic [31:0] tgt, input logic stall, input logic ready,
                       input logic allow);
    logic m_iv;
    cur_pcsel = pcsel; cur_tgt = tgt; cur_stall = stall; cur_ready = ready;
    cur_rsp   = allow && (mq.size() > 0) && (mq[0].due <= cyc);
    cur_rdata = cur_rsp ? dat(mq[0].addr) : $urandom;
    pcsel_in = pcsel; alu_target_in = tgt; stall_in = stall; imem_req_ready = ready;
    imem_rsp_valid = cur_rsp; imem_rsp_data = cur_rdata;
    #1;
    m_req_c = !pcsel && (m_out + q_buf.size() < D) && (m_drop == 0);
    m_iv    = q_buf.size() > 0;
    chk("m_req", 32'(imem_req_valid), 32'(m_req_c));
    if (m_req_c) chk("m_addr", imem_addr, m_pc);
    chk("m_iv", 32'(inst_valid_out), 32'(m_iv));
    chk("m_inst", inst_out, m_iv ? q_buf[0].inst : NOP);
    if (m_iv) begin
      chk("m_pc", pc_out, q_buf[0].pc);
      chk("m_pc4", pc4_out, q_buf[0].pc + 32'd4);
      if (q_buf[0].pc == 32'hFFFF_FFFC) chk("wrap_pc4", pc4_out, 32'h0);
    end
  endtask

  task automatic advance();
    logic        fire;
    logic [31:0] pc_old;
    fire   = m_req_c && cur_ready;
    pc_old = m_pc;
    if (cur_pcsel) begin
      m_pc = cur_tgt & 32'hFFFF_FFFC;
      q_buf.delete(); q_tags.delete();
      m_out -= int'(cur_rsp);
      m_drop = m_out;
    end else begin
      if (q_buf.size() > 0 && !cur_stall) void'(q_buf.pop_front());
      if (m_drop > 0) begin
        if (cur_rsp) begin m_drop--; m_out--; end
      end else if (cur_rsp) begin
        q_buf.push_back('{cur_rdata, q_tags.pop_front()});
        m_out--;
      end
      if (fire) begin q_tags.push_back(m_pc); m_pc += 32'd4; m_out++; end
    end
    if (cur_rsp) void'(mq.pop_front());
    if (fire) mq.push_back('{pc_old, cyc + int'($urandom_range(lat_max, lat_min))});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pcsel_in = 0; stall_in = 0; imem_req_ready = 0; imem_rsp_valid = 0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    bit got;
    logic [31:0] a0;
    reset = 1'b0; pcsel_in = 0; alu_target_in = 0; stall_in = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    cyc = 0; lat_min = 1; lat_max = 1;
    model_reset();

    vt[0]  = mk(0, 0, 0, 0, 0,             1, 32'h0,   0, 0);
    vt[1]  = mk(0, 0, 0, 1, dat(32'h0),    1, 32'h4,   0, 0);
    vt[2]  = mk(0, 0, 0, 1, dat(32'h4),    0, 0,       1, 32'h0);
    vt[3]  = mk(0, 0, 0, 0, 0,             1, 32'h8,   1, 32'h4);
    vt[4]  = mk(0, 0, 0, 1, dat(32'h8),    1, 32'hC,   0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0,             0, 0,       1, 32'h8);
    vt[6]  = mk(0, 0, 0, 1, dat(32'hC),    1, 32'h10,  0, 0);
    vt[7]  = mk(0, 0, 1, 0, 0,             0, 0,       1, 32'hC);
    vt[8]  = mk(0, 0, 1, 1, dat(32'h10),   0, 0,       1, 32'hC);
    vt[9]  = mk(0, 0, 1, 0, 0,             0, 0,       1, 32'hC);
    vt[10] = mk(0, 0, 0, 0, 0,             0, 0,       1, 32'hC);
    vt[11] = mk(0, 0, 0, 0, 0,             1, 32'h14,  1, 32'h10);
    vt[12] = mk(1, 32'h103, 0, 1, dat(32'h14), 0, 0,   0, 0);
    vt[13] = mk(0, 0, 0, 0, 0,             1, 32'h100, 0, 0);
    vt[14] = mk(0, 0, 0, 1, dat(32'h100),  1, 32'h104, 0, 0);
    vt[15] = mk(0, 0, 0, 0, 0,             0, 0,       1, 32'h100);

    repeat (2) @(negedge clk);
    #1 chk_reset_vals("rst0");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pcsel_in = vt[i].pcsel; alu_target_in = vt[i].tgt; stall_in = vt[i].stall;
      imem_req_ready = vt[i].ready; imem_rsp_valid = vt[i].rsp_v; imem_rsp_data = vt[i].rsp_d;
      #2;
      chk($sformatf("vec%0d_req", i), 32'(imem_req_valid), 32'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_iv", i), 32'(inst_valid_out), 32'(vt[i].e_iv));
      chk($sformatf("vec%0d_inst", i), inst_out, vt[i].e_inst);
      if (vt[i].e_iv) begin
        chk($sformatf("vec%0d_pc", i), pc_out, vt[i].e_pc);
        chk($sformatf("vec%0d_pc4", i), pc4_out, vt[i].e_pc + 32'd4);
      end
      @(negedge clk);
    end

    // Redirect with two requests in flight: both must be dropped.
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && m_out < 2; i++) begin drive(0, 0, 1, 1, 1); advance(); end
    drive(1, 32'h100, 1, 1, 1);
    advance();
    drive(0, 0, 0, 1, 1);
    chk("redir_flush_iv", 32'(inst_valid_out), 0);
    got = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) drive(0, 0, 0, 1, 1);
      if (imem_req_valid) begin got = 1; break; end
      advance();
    end
    if (got) chk("redir_addr", imem_addr, 32'h100); else timeout("redir_req");
    advance();
    got = 0;
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, 1, 1, 1);
      if (inst_valid_out) begin got = 1; break; end
      advance();
    end
    if (got) chk("redir_pc_out", pc_out, 32'h100); else timeout("redir_iv");
    advance();

    // Request held while ready is low.
    lat_min = 1; lat_max = 1;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, 0, 0, 1);
      if (imem_req_valid) begin got = 1; break; end
      advance();
    end
    if (!got) timeout("hold_req");
    a0 = imem_addr;
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      chk("hold_valid", 32'(imem_req_valid), 1);
      chk("hold_addr", imem_addr, a0);
      advance();
    end

    // PC wrap from the top of the address space.
    drive(1, 32'hFFFF_FFFE, 0, 1, 1);
    advance();
    got = 0;
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, 0, 1, 1);
      if (imem_req_valid) begin got = 1; break; end
      advance();
    end
    if (got) chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC); else timeout("wrap_req0");
    advance();
    got = 0;
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, 0, 1, 1);
      if (imem_req_valid) begin got = 1; break; end
      advance();
    end
    if (got) chk("wrap_addr1", imem_addr, 32'h0); else timeout("wrap_req1");
    advance();
    for (int i = 0; i < 6; i++) begin drive(0, 0, 0, 1, 1); advance(); end

    // Asynchronous reset mid-stream.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && m_out < 2; i++) begin drive(0, 0, 1, 1, 1); advance(); end
    drive(0, 0, 1, 1, 1);
    reset = 1'b0;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    model_reset();
    imem_rsp_valid = 0;
    reset = 1'b1;
    drive(0, 0, 0, 1, 1);
    chk("rst_restart_addr", imem_addr, RESET_PC);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      lat_min = 1; lat_max = 4;
      tgt = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive($urandom_range(99) < 3, tgt, $urandom_range(99) < 30, $urandom_range(99) < 70,
            $urandom_range(99) < 85);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
